// File: rtl/adc_pkg.sv
// adc_pkg: shared types and defaults for the ADC front-end channel and the
// display view mux that consumes its three 16-bit views.
package adc_pkg;

    localparam int VREF_MV_DEF = 3300;

    typedef enum logic [1:0] {
        DISP_RAW  = 2'b00,
        DISP_AVG  = 2'b01,
        DISP_VOLT = 2'b10
    } disp_mode_t;

    typedef logic [15:0] adc_view_t;

endpackage

// File: rtl/mv_scaler.sv
// mv_scaler: converts a finished block average into the scaled16 / mv views.
//   S1 captures avg16 on load, S2 holds avg16*VREF_MV and a copy of avg16,
//   and the output edge rounds the product to millivolts and publishes both
//   views together with a one-cycle out_valid.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   clear          flush: invalidates S1/S2, output registers hold
//   load, avg16    new block average entering S1
//   scaled16, mv   published views (change only together)
//   out_valid      one-cycle pulse when the views update
//   fire           combinational: the views update on this edge
module mv_scaler
    import adc_pkg::*;
#(
    parameter int VREF_MV = VREF_MV_DEF
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      clear,
    input  logic      load,
    input  adc_view_t avg16,
    output adc_view_t scaled16,
    output adc_view_t mv,
    output logic      out_valid,
    output logic      fire
);

    // vld_pipe[0] tags S1, vld_pipe[1] tags S2.
    logic [1:0]  vld_pipe;
    adc_view_t   s1_avg;
    adc_view_t   s2_avg;
    logic [31:0] s2_prod;

    // A clear on the output edge still kills the block sitting in S2.
    assign fire = vld_pipe[1] & ~clear;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            s1_avg    <= '0;
            s2_avg    <= '0;
            s2_prod   <= '0;
            scaled16  <= '0;
            mv        <= '0;
            out_valid <= 1'b0;
        end else begin
            vld_pipe  <= clear ? 2'b00 : {vld_pipe[0], load};
            out_valid <= fire;
            if (load)
                s1_avg <= avg16;
            if (vld_pipe[0]) begin
                s2_prod <= 32'(s1_avg) * 32'(VREF_MV);
                s2_avg  <= s1_avg;
            end
            // Round half up; the largest product plus 0x8000 still fits 32 bits.
            if (fire) begin
                mv       <= 16'((s2_prod + 32'h0000_8000) >> 16);
                scaled16 <= s2_avg;
            end
        end
    end

endmodule

// File: rtl/adc_block_averager.sv
// adc_block_averager: per-channel ADC front end. Accumulates 2^LOG2_N samples
// per block and hands the left-justified 16-bit average to mv_scaler.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   clear               flush partial block and in-flight conversion
//   in_valid, in_code   one-cycle sample strobe and code
//   raw16               zero-extended last accepted code
//   scaled16, mv        block average views, updated together
//   out_valid           one-cycle pulse per completed block
//   blk_cnt             completed-block counter, wraps
module adc_block_averager
    import adc_pkg::*;
#(
    parameter int RAW_W   = 8,
    parameter int LOG2_N  = 8,
    parameter int VREF_MV = VREF_MV_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [RAW_W-1:0] in_code,
    output adc_view_t        raw16,
    output adc_view_t        scaled16,
    output adc_view_t        mv,
    output logic             out_valid,
    output logic [7:0]       blk_cnt
);

    localparam int ACC_W = RAW_W + LOG2_N;

    if (ACC_W < 16 || LOG2_N < 1 || LOG2_N > 12) begin : g_bad_params
        $error("adc_block_averager: need RAW_W+LOG2_N >= 16 and LOG2_N in 1..12");
    end

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [LOG2_N-1:0] cnt;
    logic              accept;
    logic              last;
    adc_view_t         avg16;
    logic              fire;

    assign accept = in_valid & ~clear;
    assign last   = accept && (cnt == '1);
    // A full block of max codes fits ACC_W exactly, so no carry is lost.
    assign sum    = acc + ACC_W'(in_code);
    assign avg16  = 16'(sum >> (ACC_W - 16));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            raw16 <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            raw16 <= 16'(in_code);
            cnt   <= cnt + 1'b1;
            acc   <= last ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            blk_cnt <= '0;
        else if (fire)
            blk_cnt <= blk_cnt + 8'd1;
    end

    mv_scaler #(
        .VREF_MV (VREF_MV)
    ) u_scaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (last),
        .avg16     (avg16),
        .scaled16  (scaled16),
        .mv        (mv),
        .out_valid (out_valid),
        .fire      (fire)
    );

endmodule

// File: tb/tb_adc_block_averager.sv
module tb_adc_block_averager;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_code;
    logic [15:0] raw16, scaled16, mv;
    logic        out_valid;
    logic [7:0]  blk_cnt;

    adc_block_averager #(.RAW_W(8), .LOG2_N(8), .VREF_MV(3300)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .raw16     (raw16),
        .scaled16  (scaled16),
        .mv        (mv),
        .out_valid (out_valid),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int edges      = 0;
    int pulses     = 0;
    bit mon_en     = 0;

    always @(posedge clk) edges <= edges + 1;

    // Reference model: a block is just the list of accepted codes since the
    // last flush; 256 of them produce a result due two edges later.
    typedef struct { int due; longint avg; } pend_t;
    pend_t  pend[$];
    int     m_cnt = 0;
    longint m_sum = 0;
    int     m_raw = 0, m_scaled = 0, m_mv = 0, m_blk = 0;

    function automatic int to_mv(longint avg);
        return int'((avg * 3300 + 32768) / 65536);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s @edge %0d: got %0h expected %0h", name, edges, act, exp);
        end
    endtask

    // One clock edge with the given inputs, then the model follows that edge.
    task automatic step(input bit v, input int code, input bit clr, input bit rst_n = 1'b1);
        in_valid = v;
        in_code  = 8'(code);
        clear    = clr;
        reset_n  = rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_cnt = 0; m_sum = 0; m_raw = 0; m_scaled = 0; m_mv = 0; m_blk = 0;
            pend.delete();
        end else if (clr) begin
            m_cnt = 0; m_sum = 0;
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].due >= edges) pend.delete(i);
        end else if (v) begin
            m_raw = code;
            m_sum += code;
            m_cnt++;
            if (m_cnt == 256) begin
                pend.push_back('{due: edges + 2, avg: m_sum});
                m_cnt = 0; m_sum = 0;
            end
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic block(input int code, input int n);
        for (int i = 0; i < n; i++) step(1'b1, code, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_v;
            exp_v = (pend.size() > 0 && pend[0].due == edges);
            if (exp_v) begin
                m_scaled = int'(pend[0].avg);
                m_mv     = to_mv(pend[0].avg);
                m_blk    = (m_blk + 1) % 256;
                void'(pend.pop_front());
            end
            if (out_valid) pulses++;
            check("out_valid", out_valid, exp_v);
            check("raw16",     raw16,     m_raw);
            check("scaled16",  scaled16,  m_scaled);
            check("mv",        mv,        m_mv);
            check("blk_cnt",   blk_cnt,   m_blk);
        end
    end

    typedef struct {
        int code_even;
        int code_odd;
        int exp_scaled;
        int exp_mv;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   pb;

        tbl[0] = '{8'h80, 8'h80, 16'h8000, 1650};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFF00, 3287};
        tbl[2] = '{8'h00, 8'h00, 16'h0000, 0};
        tbl[3] = '{8'h00, 8'h01, 16'h0080, 6};
        tbl[4] = '{8'h40, 8'h40, 16'h4000, 825};
        tbl[5] = '{8'h10, 8'h10, 16'h1000, 206};

        in_valid = 0; in_code = 0; clear = 0; reset_n = 0;
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        mon_en = 1;
        @(negedge clk);
        check("rst_raw16", raw16, 0);
        check("rst_scaled16", scaled16, 0);
        check("rst_mv", mv, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_out_valid", out_valid, 0);

        // Constant-pattern blocks with hand-computed results.
        for (int t = 0; t < 6; t++) begin
            pb = pulses;
            for (int i = 0; i < 256; i++)
                step(1'b1, (i % 2) ? tbl[t].code_odd : tbl[t].code_even, 1'b0);
            idle(4);
            check("tbl_pulses", pulses - pb, 1);
            check("tbl_scaled16", scaled16, tbl[t].exp_scaled);
            check("tbl_mv", mv, tbl[t].exp_mv);
        end
        check("tbl_blk_cnt", blk_cnt, 6);

        // Back-to-back blocks with no gap.
        pb = pulses;
        block(8'hFF, 256);
        block(8'h00, 256);
        idle(4);
        check("b2b_pulses", pulses - pb, 2);
        check("b2b_scaled16", scaled16, 0);
        check("b2b_raw16", raw16, 0);

        // Partial block flushed by clear.
        pb = pulses;
        block(8'hFF, 100);
        step(1'b0, 0, 1'b1);
        block(8'h40, 256);
        idle(4);
        check("clr_pulses", pulses - pb, 1);
        check("clr_scaled16", scaled16, 16'h4000);
        check("clr_mv", mv, 825);

        // Clear together with a sample: sample dropped, raw16 holds.
        pb = pulses;
        block(8'h05, 10);
        step(1'b1, 8'h33, 1'b1);
        @(negedge clk);
        check("clrv_raw16", raw16, 8'h05);
        block(8'h07, 255);
        idle(4);
        check("clrv_pulses_255", pulses - pb, 0);
        block(8'h07, 1);
        idle(4);
        check("clrv_pulses_256", pulses - pb, 1);
        check("clrv_scaled16", scaled16, 16'h0700);

        // Clear while the finished block is in S1, then in S2.
        pb = pulses;
        block(8'h22, 256);
        step(1'b0, 0, 1'b1);
        idle(5);
        check("clr_s1_pulses", pulses - pb, 0);
        block(8'h23, 256);
        idle(1);
        step(1'b0, 0, 1'b1);
        idle(5);
        check("clr_s2_pulses", pulses - pb, 0);
        check("clr_s2_scaled16", scaled16, 16'h0700);

        // Randomized traffic with gaps and rare clears.
        for (int i = 0; i < 1800; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 299) == 0);
        idle(4);

        // Reset in the middle of a block.
        block(8'h10, 200);
        step(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("mrst_raw16", raw16, 0);
        check("mrst_scaled16", scaled16, 0);
        check("mrst_mv", mv, 0);
        check("mrst_blk_cnt", blk_cnt, 0);
        pb = pulses;
        block(8'h10, 256);
        idle(4);
        check("mrst_pulses", pulses - pb, 1);
        check("mrst_scaled16_after", scaled16, 16'h1000);
        check("mrst_mv_after", mv, 206);
        check("mrst_blk_cnt_after", blk_cnt, 1);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
